// File: rtl/booth_pp_sequencer.sv
// Radix-4 Booth multiplier sequencer: 8x8 signed, one partial product per RUN cycle.
// Optional macro BOOTH_EARLY_TERM_EN ends RUN once all remaining Booth digits are zero.
module booth_pp_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        ppNum,
  output logic [1:0]  ppIndex,
  output logic [9:0]  partialProduct
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_next;
  logic [7:0]  a_reg, b_reg;
  logic [15:0] acc;
  logic [1:0]  idx;
  logic [8:0]  b_ext;
  logic [2:0]  triplet;
  logic [9:0]  a_ext;
  logic [9:0]  pp;
  logic [15:0] addend;
  logic        last_digit;

  // Appending a zero below bit 0 supplies the implicit B[-1] for digit 0.
  assign b_ext   = {b_reg, 1'b0};
  assign triplet = b_ext[{idx, 1'b0} +: 3];
  assign a_ext   = {{2{a_reg[7]}}, a_reg};
  assign addend  = {{6{pp[9]}}, pp} << {idx, 1'b0};

`ifdef BOOTH_EARLY_TERM_EN
  logic rest_uniform;

  // Remaining digits are all zero when the untouched multiplier bits are pure sign copies.
  always_comb begin
    rest_uniform = 1'b0;
    case (idx)
      2'd0:    rest_uniform = (&b_reg[7:1]) | ~(|b_reg[7:1]);
      2'd1:    rest_uniform = (&b_reg[7:3]) | ~(|b_reg[7:3]);
      2'd2:    rest_uniform = (&b_reg[7:5]) | ~(|b_reg[7:5]);
      default: rest_uniform = 1'b1;
    endcase
  end

  assign last_digit = (idx == 2'd3) | rest_uniform;
`else
  assign last_digit = (idx == 2'd3);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    ppNum      = 1'b0;
    pp         = '0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy  = 1'b1;
        ppNum = (idx == 2'd0);
        case (triplet)
          3'b001, 3'b010: pp = a_ext;
          3'b011:         pp = a_ext << 1;
          3'b100:         pp = 10'd0 - (a_ext << 1);
          3'b101, 3'b110: pp = 10'd0 - a_ext;
          default:        pp = '0;
        endcase
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands are latched only on an accepted start, so later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= multiplicand;
            b_reg <= multiplier;
            acc   <= '0;
            idx   <= '0;
          end
        end
        RUN: begin
          acc <= acc + addend;
          idx <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign product        = acc;
  assign ppIndex        = idx;
  assign partialProduct = pp;

endmodule

// File: doc/booth_pp_sequencer.md
BOOTH_PP_SEQUENCER -- requirements
Module: booth_pp_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous to clk, active-low.
REQ-003 SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-004 SHALL have port multiplicand, input, 8 bits: signed two's-complement operand A.
REQ-005 SHALL have port multiplier, input, 8 bits: signed two's-complement operand B.
REQ-006 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse; product valid.
REQ-008 SHALL have port product, output, 16 bits: signed result A*B.
REQ-009 SHALL have port ppNum, output, 1 bit: high only while the first partial product (index 0) is issued; feeds the sign-extender select.
REQ-010 SHALL have port ppIndex, output, 2 bits: index of the Booth digit being processed.
REQ-011 SHALL have port partialProduct, output, 10 bits: current signed partial product, digit*A, sign-extended to 10 bits.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL, in IDLE with start=1 at a clock edge, capture A and B, clear the accumulator to 0, set ppIndex=0 and go to RUN.
REQ-014 SHALL, in RUN, use radix-4 Booth digit i from bits {B[2i+1], B[2i], B[2i-1]}, with B[-1]=0, and the encoding 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1.
REQ-015 SHALL, in RUN each cycle, drive partialProduct = digit*A (10-bit signed) combinationally and add it to the 16-bit accumulator, sign-extended and shifted left by 2*ppIndex, at the clock edge.
REQ-016 SHALL, in RUN, increment ppIndex each cycle and go to DONE after the edge that processes ppIndex=3.
REQ-017 SHALL, in DONE, assert done=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-018 SHALL keep product equal to the accumulator and hold it stable from DONE until the next accepted start.
REQ-019 SHALL give a latency from the start-accept edge to done=1 of 5 cycles (4 RUN cycles plus DONE).
REQ-020 SHALL ignore start while in RUN or DONE; no queueing and no restart.
REQ-021 SHALL ignore changes to the operand inputs after capture.
REQ-022 SHALL drive partialProduct=0 and ppNum=0 outside RUN.
REQ-023 SHALL take the product modulo 2^16; this is exact for all 8-bit signed pairs, including -128*-128 = 0x4000.

Reset
REQ-024 SHALL, while rst_n=0 at a clock edge, enter IDLE with busy=0, done=0, product=0x0000, ppIndex=0, ppNum=0 and partialProduct=0.
REQ-025 SHALL let reset asserted mid-RUN or in DONE abort the operation; no done pulse results and the next start begins cleanly.
REQ-026 SHALL give rst_n priority over start on the same edge.

Configuration
REQ-027 SHALL, when macro BOOTH_EARLY_TERM_EN is defined, go from RUN directly to DONE after processing digit i whenever captured bits B[7:2i+1] are all equal (all remaining digits are zero); latency is then 2 + i cycles.
REQ-028 SHALL, when BOOTH_EARLY_TERM_EN is undefined, always process all 4 digits, with a fixed latency of 5 cycles.
REQ-029 SHALL produce an identical product either way; only timing, busy and ppIndex sequencing differ.

Verification
REQ-030 SHALL cover: A=3, B=5, start pulse -> ppNum=1 only in the first RUN cycle; done after 5 cycles; product=0x000F.
REQ-031 SHALL cover: A=-128, B=-128 -> product=0x4000; A=127, B=-128 -> product=0xC080.
REQ-032 SHALL cover: start held high during RUN -> exactly one done pulse; second start accepted only after return to IDLE.
REQ-033 SHALL cover: rst_n=0 at the 2nd RUN cycle -> IDLE next edge, product=0, no done; a new start with A=2, B=-3 -> product=0xFFFA.
REQ-034 SHALL cover: A=7, B=1 with BOOTH_EARLY_TERM_EN -> done 2 cycles after start and product=0x0007; the same stimulus without the macro -> done after 5 cycles with the same product.
REQ-035 SHALL cover: random 1000 operand pairs, both macro settings -> product equals the signed reference multiply.
